module_display_bcd_seven: RTL and testbench
===========================================

MODULE_DISPLAY_BCD_SEVEN -- requirements
Module: module_display_bcd_seven

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each display digit stays selected (legal range >=1).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset.
REQ-004 q  input  7  binary count from the upstream 7-bit counter, 0..127.
REQ-005 carry  input  1  terminal-count carry from the upstream counter.
REQ-006 seg  output  7  active-low segments, seg[0]=a .. seg[6]=g, for the selected digit.
REQ-007 an  output  3  active-low one-hot digit select: an[0]=units, an[1]=tens, an[2]=hundreds.
REQ-008 done  output  1  one-cycle pulse when new digits are loaded.
REQ-009 ovf  output  1  sticky flag: upstream counter has wrapped at least once.

Function
REQ-010 FSM states IDLE, CONVERT, LOAD; encodings SHALL come from the shared package.
REQ-011 IDLE: at each edge, if q != last_value, the block SHALL latch q into the shift register and last_value, clear the BCD register, and enter CONVERT. Otherwise it SHALL stay in IDLE.
REQ-012 CONVERT: seven edges of shift-and-add-3 (add 3 to any BCD nibble >=5, then shift left one bit). After the 7th step the FSM SHALL enter LOAD.
REQ-013 LOAD: one edge SHALL copy the hundreds/tens/units BCD into the digit registers, assert done for exactly that cycle, and return to IDLE.
REQ-014 Latency: if q is sampled at edge E0, the digit registers and done SHALL update at edge E8. The next sample SHALL be possible no earlier than E9.
REQ-015 Changes of q during CONVERT or LOAD SHALL be ignored. The latest value SHALL be picked up at the first IDLE edge after the change.
REQ-016 Hundreds digit SHALL be 0 or 1. Tens and units SHALL be 0..9. No BCD nibble may ever exceed 9.
REQ-017 Blanking: hundreds SHALL be blank when 0. Tens SHALL be blank when hundreds and tens are both 0. Units SHALL never be blank.
REQ-018 Blank pattern SHALL be seg=1111111. Digits 0..9 SHALL use the standard active-low gfedcba codes.
REQ-019 Scan: a prescaler SHALL count 0..SCAN_DIV-1. On wrap, an SHALL rotate units->tens->hundreds->units, independent of FSM state.
REQ-020 seg and an SHALL be registered and change on the same edge, with no cycle of mismatch.
REQ-021 ovf SHALL set on any edge where carry=1 and SHALL remain set until clr. When carry and a conversion start occur in the same cycle, both SHALL be serviced.

Reset
REQ-022 clr=1 SHALL immediately force: state=IDLE, last_value=0, BCD and digit registers=0, prescaler=0, an=110, seg=1000000 (units "0"), done=0, ovf=0.
REQ-023 clr asserted mid-CONVERT or mid-LOAD SHALL abort the conversion, and no done pulse SHALL follow.
REQ-024 After clr deasserts with q=0, no conversion SHALL start. The display SHALL show "0".

Structure
REQ-025 A shared package SHALL hold the FSM state encodings, the segment codes for 0..9 and blank, the digit count (3), and the conversion step count (7).
REQ-026 One combinational sub-module, module_bcd_to_seven_seg (4-bit BCD plus blank flag in, 7-bit seg out), SHALL be instantiated once on the selected digit.

Verification
REQ-027 Reset, then q=127 held -> done pulses 8 edges after the sample; digits 1,2,7; scan shows seg 1111001 / 0100100 / 1111000 on an 011 / 101 / 110.
REQ-028 q=5 -> hundreds and tens show 1111111; units 0010010.
REQ-029 q changes 10->99 at the 3rd CONVERT edge -> first done shows 10; a second conversion starts at the next IDLE edge; the second done shows 99.
REQ-030 carry=1 for one cycle -> ovf=1 from the next edge and held through 200 cycles; clr -> ovf=0.
REQ-031 clr pulsed during CONVERT of q=64 -> no done, display "0". After release with q=64 still applied, the conversion completes and shows 64.
REQ-032 SCAN_DIV=1 and SCAN_DIV=4 -> each an value is held exactly 1 and 4 cycles respectively, and exactly one an bit is low at all times.

Source files
------------

// File: rtl/module_display_bcd_seven_pkg.sv
// rtl/module_display_bcd_seven_pkg.sv - shared encodings, segment codes and BCD helper for the display block
package module_display_bcd_seven_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LOAD    = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 3;
    localparam int CONV_STEPS = 7;

    // Active-low gfedcba codes, seg[0]=a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Pre-shift correction: any nibble >= 5 becomes >= 8 so the shift carries into the next digit
    function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/module_display_bcd_seven_bcd_to_seven_seg.sv
// rtl/module_display_bcd_seven_bcd_to_seven_seg.sv - combinational BCD digit to active-low segment decoder
module module_bcd_to_seven_seg
    import module_display_bcd_seven_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/module_display_bcd_seven.sv
// rtl/module_display_bcd_seven.sv - binary-to-BCD converter driving a scanned 3-digit seven-segment display
module module_display_bcd_seven
    import module_display_bcd_seven_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [6:0]            q,
    input  logic                  carry,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  done,
    output logic                  ovf
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t        state, state_n;
    logic [6:0]    last_value, shift_reg;
    logic [11:0]   bcd;
    logic [2:0]    step;
    logic [3:0]    dig_h, dig_t, dig_u;
    logic [3:0]    dig_h_n, dig_t_n, dig_u_n;
    logic          start, do_step, do_load;
    logic [PW-1:0] presc;
    logic          wrap;
    logic [2:0]    an_n;
    logic [3:0]    sel_bcd;
    logic          sel_blank;
    logic [6:0]    seg_n;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        do_step = 1'b0;
        do_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (q != last_value) begin
                    start   = 1'b1;
                    state_n = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                do_step = 1'b1;
                if (step == 3'(CONV_STEPS - 1)) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                do_load = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            last_value <= '0;
            shift_reg  <= '0;
            bcd        <= '0;
            step       <= '0;
        end else if (start) begin
            last_value <= q;
            shift_reg  <= q;
            bcd        <= '0;
            step       <= '0;
        end else if (do_step) begin
            {bcd, shift_reg} <= {dabble_adjust(bcd), shift_reg} << 1;
            step             <= step + 3'd1;
        end
    end

    assign dig_h_n = do_load ? bcd[11:8] : dig_h;
    assign dig_t_n = do_load ? bcd[7:4]  : dig_t;
    assign dig_u_n = do_load ? bcd[3:0]  : dig_u;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dig_h <= '0;
            dig_t <= '0;
            dig_u <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            dig_h <= dig_h_n;
            dig_t <= dig_t_n;
            dig_u <= dig_u_n;
            done  <= do_load;
            if (carry) ovf <= 1'b1;
        end
    end

    // Decode from next-cycle digit/select values so seg and an always agree on the same edge
    assign wrap = (presc == PW'(SCAN_DIV - 1));
    assign an_n = wrap ? {an[1:0], an[2]} : an;

    always_comb begin
        sel_bcd   = dig_u_n;
        sel_blank = 1'b0;
        case (an_n)
            3'b101: begin
                sel_bcd   = dig_t_n;
                sel_blank = (dig_h_n == 4'd0) && (dig_t_n == 4'd0);
            end
            3'b011: begin
                sel_bcd   = dig_h_n;
                sel_blank = (dig_h_n == 4'd0);
            end
            default: ;
        endcase
    end

    module_bcd_to_seven_seg u_dec (
        .bcd   (sel_bcd),
        .blank (sel_blank),
        .seg   (seg_n)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc <= '0;
            an    <= 3'b110;
            seg   <= SEG_0;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            an    <= an_n;
            seg   <= seg_n;
        end
    end

endmodule

// File: tb/tb_module_display_bcd_seven.sv
// tb/tb_module_display_bcd_seven.sv - self-checking bench for module_display_bcd_seven
module tb_module_display_bcd_seven;

    typedef struct {
        logic [6:0] v;
        logic [6:0] sh;
        logic [6:0] st;
        logic [6:0] su;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       carry = 1'b0;
    logic [6:0] q = 7'd0;
    logic [6:0] seg, seg1;
    logic [2:0] an, an1;
    logic       done, done1, ovf, ovf1;

    int   total = 0;
    int   bad = 0;
    vec_t exp_q[$];
    vec_t mon_r;
    vec_t tbl[10];
    vec_t r0, r10, r99, r64, r38;

    always #5 clk = ~clk;

    module_display_bcd_seven #(.SCAN_DIV(4)) dut (
        .clk(clk), .clr(clr), .q(q), .carry(carry),
        .seg(seg), .an(an), .done(done), .ovf(ovf)
    );

    module_display_bcd_seven #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .clr(clr), .q(q), .carry(carry),
        .seg(seg1), .an(an1), .done(done1), .ovf(ovf1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    function automatic logic [6:0] exp_seg(input vec_t r, input logic [2:0] a);
        case (a)
            3'b110:  return r.su;
            3'b101:  return r.st;
            3'b011:  return r.sh;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    function automatic int zeros3(input logic [2:0] a);
        return int'(!a[0]) + int'(!a[1]) + int'(!a[2]);
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done actual=1 required=0");
            end else begin
                mon_r = exp_q.pop_front();
                chk($sformatf("done_seg_%0d", mon_r.v), seg, exp_seg(mon_r, an));
                chk($sformatf("done_seg1_%0d", mon_r.v), seg1, exp_seg(mon_r, an1));
            end
        end
    end

    task automatic check_scan(input vec_t r);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("onehot_%0d", r.v), zeros3(an), 1);
            chk($sformatf("scan_%0d_an%b", r.v, an), seg, exp_seg(r, an));
            chk($sformatf("scan1_%0d_an%b", r.v, an1), seg1, exp_seg(r, an1));
        end
    endtask

    task automatic wait_done(input string nm, input int n_start, input int expn);
        int n;
        n = n_start;
        while (!done && n < expn + 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n, expn);
    endtask

    task automatic apply(input vec_t r, input logic c);
        @(negedge clk);
        q = r.v;
        carry = c;
        exp_q.push_back(r);
        if (c) begin
            @(negedge clk);
            carry = 1'b0;
            chk("ovf_with_start", ovf, 1'b1);
            wait_done($sformatf("latency_%0d", r.v), 1, 9);
        end else begin
            wait_done($sformatf("latency_%0d", r.v), 0, 9);
        end
        check_scan(r);
    endtask

    task automatic measure_hold(input int which, input int expn);
        logic [2:0] p;
        int n;
        p = which ? an1 : an;
        n = 0;
        while ((which ? an1 : an) == p && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            p = which ? an1 : an;
            n = 0;
            while ((which ? an1 : an) == p && n < 20) begin
                @(negedge clk);
                n++;
                chk($sformatf("onehot_hold%0d", which), zeros3(which ? an1 : an), 1);
            end
            chk($sformatf("hold_div%0d_an%b", expn, p), n, expn);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{7'd127, 7'b1111001, 7'b0100100, 7'b1111000};
        tbl[1] = '{7'd5,   7'b1111111, 7'b1111111, 7'b0010010};
        tbl[2] = '{7'd100, 7'b1111001, 7'b1000000, 7'b1000000};
        tbl[3] = '{7'd105, 7'b1111001, 7'b1000000, 7'b0010010};
        tbl[4] = '{7'd38,  7'b1111111, 7'b0110000, 7'b0000000};
        tbl[5] = '{7'd9,   7'b1111111, 7'b1111111, 7'b0010000};
        tbl[6] = '{7'd64,  7'b1111111, 7'b0000010, 7'b0011001};
        tbl[7] = '{7'd10,  7'b1111111, 7'b1111001, 7'b1000000};
        tbl[8] = '{7'd99,  7'b1111111, 7'b0010000, 7'b0010000};
        tbl[9] = '{7'd0,   7'b1111111, 7'b1111111, 7'b1000000};
        r0  = tbl[9];
        r10 = tbl[7];
        r99 = tbl[8];
        r64 = tbl[6];
        r38 = tbl[4];

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 7'b1000000);
        chk("rst_an", an, 3'b110);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_an1", an1, 3'b110);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        check_scan(r0);

        for (int i = 0; i < 10; i++) apply(tbl[i], 1'b0);

        // q changes during conversion: first result is the old value, second follows at once
        @(negedge clk);
        q = r10.v;
        exp_q.push_back(r10);
        repeat (3) @(negedge clk);
        q = r99.v;
        exp_q.push_back(r99);
        wait_done("midchange_first", 3, 9);
        @(negedge clk);
        wait_done("midchange_second", 10, 18);
        check_scan(r99);

        // sticky overflow
        @(negedge clk);
        chk("ovf_before", ovf, 1'b0);
        carry = 1'b1;
        @(negedge clk);
        carry = 1'b0;
        chk("ovf_set", ovf, 1'b1);
        repeat (200) @(negedge clk);
        chk("ovf_held", ovf, 1'b1);
        chk("ovf1_held", ovf1, 1'b1);
        #2 clr = 1'b1;
        #1 chk("ovf_clr", ovf, 1'b0);

        // clr during conversion of 64
        @(negedge clk);
        q = 7'd0;
        clr = 1'b0;
        @(negedge clk);
        q = r64.v;
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("abort_seg", seg, 7'b1000000);
        chk("abort_an", an, 3'b110);
        chk("abort_done", done, 1'b0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", done, 1'b0);
        exp_q.push_back(r64);
        clr = 1'b0;
        wait_done("after_abort_latency", 0, 9);
        check_scan(r64);

        // carry coincident with a conversion start
        apply(r38, 1'b1);

        measure_hold(0, 4);
        measure_hold(1, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
